// File: rtl/fox86_memctl.sv
// Memory controller for the fox86 CPU: routes each access to the on-chip ROM or to the external bus.
// It advances the CPU with a one-cycle cpu_ce pulse and aborts stalled external accesses with bus_error.
module fox86_memctl #(
  parameter logic [3:0] ROM_SEG = 4'hF,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        cpu_ce,
  output logic [15:0] rom_address,
  input  logic [7:0]  rom_data,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROM_ADDR = 3'd1,
    ROM_DATA = 3'd2,
    MEMWAIT  = 3'd3,
    DONE     = 3'd4
  } state_t;

  // External handshake: mem_req is a level held from IDLE until the MEMWAIT cycle
  // that sees mem_ack (or times out); address/we/wdata stay stable throughout, and
  // mem_ack is only looked at while in MEMWAIT.
  state_t      state_q, state_d;
  logic [7:0]  cpu_in_q, cpu_in_d;
  logic        cpu_ce_q, cpu_ce_d;
  logic [15:0] rom_address_q, rom_address_d;
  logic [19:0] mem_address_q, mem_address_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_req_q, mem_req_d;
  logic        bus_error_q, bus_error_d;
  logic [7:0]  count_q, count_d;
  logic        we_q, we_d;

  always_comb begin
    state_d       = state_q;
    cpu_in_d      = cpu_in_q;
    cpu_ce_d      = 1'b0;
    rom_address_d = rom_address_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = mem_we_q;
    mem_req_d     = mem_req_q;
    bus_error_d   = 1'b0;
    count_d       = count_q;
    we_d          = we_q;
    case (state_q)
      IDLE: begin
        we_d    = cpu_we;
        count_d = 8'd0;
        if (cpu_address[19:16] == ROM_SEG) begin
          if (cpu_we) begin
            // ROM is read-only: finish the write at once without touching the ROM port
            cpu_ce_d = 1'b1;
            state_d  = DONE;
          end else begin
            rom_address_d = cpu_address[15:0];
            state_d       = ROM_ADDR;
          end
        end else begin
          mem_req_d     = 1'b1;
          mem_address_d = cpu_address;
          mem_we_d      = cpu_we;
          mem_wdata_d   = cpu_out;
          state_d       = MEMWAIT;
        end
      end
      ROM_ADDR: state_d = ROM_DATA;
      ROM_DATA: begin
        cpu_in_d = rom_data;
        cpu_ce_d = 1'b1;
        state_d  = DONE;
      end
      MEMWAIT: begin
        // ack is tested first so it wins over a timeout in the same cycle
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!we_q) cpu_in_d = mem_rdata;
          cpu_ce_d  = 1'b1;
          state_d   = DONE;
        end else if (count_q == TIMEOUT) begin
          mem_req_d   = 1'b0;
          if (!we_q) cpu_in_d = 8'hFF;
          cpu_ce_d    = 1'b1;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cpu_in_q      <= 8'h00;
      cpu_ce_q      <= 1'b0;
      rom_address_q <= 16'h0000;
      mem_address_q <= 20'h00000;
      mem_wdata_q   <= 8'h00;
      mem_we_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      bus_error_q   <= 1'b0;
      count_q       <= 8'd0;
      we_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_in_q      <= cpu_in_d;
      cpu_ce_q      <= cpu_ce_d;
      rom_address_q <= rom_address_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      mem_req_q     <= mem_req_d;
      bus_error_q   <= bus_error_d;
      count_q       <= count_d;
      we_q          <= we_d;
    end
  end

  assign cpu_in      = cpu_in_q;
  assign cpu_ce      = cpu_ce_q;
  assign rom_address = rom_address_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_req     = mem_req_q;
  assign bus_error   = bus_error_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fox86_memctl.sv
// Directed bench for fox86_memctl: ROM reads/writes, external accesses, timeout and reset abort.
// Cycle 0 is the IDLE cycle right after reset release; outputs are sampled 1ns after each edge.
module tb_fox86_memctl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] cpu_address = '0;
  logic [7:0]  cpu_out = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_in;
  logic        cpu_ce;
  logic [15:0] rom_address;
  logic [7:0]  rom_data = '0;
  logic [19:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        bus_error;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  fox86_memctl dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
    .cpu_in(cpu_in), .cpu_ce(cpu_ce),
    .rom_address(rom_address), .rom_data(rom_data),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_error(bus_error), .dbg_state(dbg_state)
  );

  always #20 clock = ~clock;

  // Synchronous ROM model: ROM[0x0010]=EA, elsewhere low byte plus 0x11
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    if (a == 16'h0010) return 8'hEA;
    return a[7:0] + 8'h11;
  endfunction

  always @(posedge clock) rom_data <= rom_byte(rom_address);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset, load CPU request, release reset: returns during cycle 0
  task automatic start(input logic [19:0] a, input logic we, input logic [7:0] d);
    @(negedge clock);
    reset_n     = 1'b0;
    mem_ack     = 1'b0;
    cpu_address = a;
    cpu_we      = we;
    cpu_out     = d;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int hi;

    // Reset state
    start(20'h00000, 1'b0, 8'h00);
    chk("rst_cpu_ce", cpu_ce, 0);
    chk("rst_cpu_in", cpu_in, 8'h00);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_rom_address", rom_address, 16'h0000);
    chk("rst_mem_address", mem_address, 20'h00000);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_state", dbg_state, 3'd0);

    // ROM read at 0xF0010
    start(20'hF0010, 1'b0, 8'h00);
    step(); // cycle 1
    chk("romrd_c1_addr", rom_address, 16'h0010);
    chk("romrd_c1_ce", cpu_ce, 0);
    chk("romrd_c1_req", mem_req, 0);
    step(); // cycle 2
    chk("romrd_c2_ce", cpu_ce, 0);
    step(); // cycle 3
    chk("romrd_c3_ce", cpu_ce, 1);
    chk("romrd_c3_data", cpu_in, 8'hEA);
    step(); // cycle 4
    chk("romrd_c4_ce", cpu_ce, 0);
    chk("romrd_c4_data", cpu_in, 8'hEA);

    // ROM read at top of ROM
    start(20'hFFFFF, 1'b0, 8'h00);
    step();
    chk("romtop_addr", rom_address, 16'hFFFF);
    step();
    step();
    chk("romtop_ce", cpu_ce, 1);
    chk("romtop_data", cpu_in, 8'h10);

    // 0xEFFFF is external
    start(20'hEFFFF, 1'b0, 8'h00);
    step();
    chk("ext_eff_req", mem_req, 1);
    chk("ext_eff_addr", mem_address, 20'hEFFFF);
    chk("ext_eff_rom", rom_address, 16'h0000);

    // External write at 0x00400, ack in the 5th request cycle
    start(20'h00400, 1'b1, 8'h5A);
    hi = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (mem_req) hi++;
      if (i == 5) mem_ack = 1'b1;
    end
    chk("extwr_we", mem_we, 1);
    chk("extwr_wdata", mem_wdata, 8'h5A);
    chk("extwr_addr", mem_address, 20'h00400);
    chk("extwr_pre_ce", cpu_ce, 0);
    step(); // cycle 6
    mem_ack = 1'b0;
    chk("extwr_req_cycles", hi, 5);
    chk("extwr_ce", cpu_ce, 1);
    chk("extwr_req_drop", mem_req, 0);
    chk("extwr_cpu_in", cpu_in, 8'h00);
    step();
    chk("extwr_ce_off", cpu_ce, 0);

    // External read at 0x12345, zero-wait ack
    start(20'h12345, 1'b0, 8'h00);
    step(); // cycle 1
    chk("extrd_c1_req", mem_req, 1);
    chk("extrd_c1_we", mem_we, 0);
    chk("extrd_c1_ce", cpu_ce, 0);
    mem_ack   = 1'b1;
    mem_rdata = 8'h3C;
    step(); // cycle 2
    mem_ack = 1'b0;
    chk("extrd_c2_ce", cpu_ce, 1);
    chk("extrd_c2_data", cpu_in, 8'h3C);
    chk("extrd_c2_req", mem_req, 0);
    chk("extrd_c2_berr", bus_error, 0);

    // Timeout: no ack ever
    start(20'h20000, 1'b0, 8'h00);
    hi = 0;
    for (int i = 1; i <= 256; i++) begin
      step();
      if (mem_req) hi++;
    end
    chk("to_req_cycles", hi, 256);
    chk("to_pre_ce", cpu_ce, 0);
    step(); // cycle 257
    chk("to_req_drop", mem_req, 0);
    chk("to_ce", cpu_ce, 1);
    chk("to_berr", bus_error, 1);
    chk("to_data", cpu_in, 8'hFF);
    step();
    chk("to_ce_off", cpu_ce, 0);
    chk("to_berr_off", bus_error, 0);

    // Ack in the same cycle as the timeout: ack wins
    start(20'h30000, 1'b0, 8'h00);
    for (int i = 1; i <= 256; i++) step();
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    step(); // cycle 257
    mem_ack = 1'b0;
    chk("tie_ce", cpu_ce, 1);
    chk("tie_berr", bus_error, 0);
    chk("tie_data", cpu_in, 8'h77);

    // ROM write at 0xFFFF0 is discarded
    start(20'hFFFF0, 1'b1, 8'h99);
    step(); // cycle 1
    chk("romwr_ce", cpu_ce, 1);
    chk("romwr_req", mem_req, 0);
    chk("romwr_rom", rom_address, 16'h0000);
    chk("romwr_data", cpu_in, 8'h00);
    step();
    chk("romwr_ce_off", cpu_ce, 0);

    // Reset during MEMWAIT, late ack afterwards
    start(20'h40000, 1'b1, 8'hC3);
    step(); // cycle 1
    step(); // cycle 2
    chk("rmw_c2_req", mem_req, 1);
    reset_n = 1'b0;
    step(); // cycle 3
    chk("rmw_c3_req", mem_req, 0);
    chk("rmw_c3_ce", cpu_ce, 0);
    chk("rmw_c3_state", dbg_state, 3'd0);
    chk("rmw_c3_addr", mem_address, 20'h00000);
    chk("rmw_c3_wdata", mem_wdata, 8'h00);
    chk("rmw_c3_we", mem_we, 0);
    reset_n     = 1'b1;
    mem_ack     = 1'b1;
    cpu_address = 20'hF0010;
    cpu_we      = 1'b0;
    step(); // cycle 4
    chk("rmw_c4_ce", cpu_ce, 0);
    chk("rmw_c4_req", mem_req, 0);
    chk("rmw_c4_berr", bus_error, 0);
    step();
    mem_ack = 1'b0;
    chk("rmw_c5_ce", cpu_ce, 0);
    chk("rmw_c5_data", cpu_in, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
